input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, stable cycles required to accept a new input level (minimum 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, cycles from press pulse to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port sw_raw, input, 4, asynchronous switches {sw4,sw3,sw2,sw1}, active-high.
REQ-007 SHALL have port key_raw, input, 3, asynchronous pushbuttons {key3,key2,key0}, active-low.
REQ-008 SHALL have port sw_db, output, 4, debounced switch levels, active-high.
REQ-009 SHALL have port key_db, output, 3, debounced key levels, active-low, same bit order as key_raw.
REQ-010 SHALL have port key_press, output, 3, active-high single-cycle press/repeat pulses, same bit order.

Function
REQ-011 Each of the 7 inputs SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Per input, the debounce counter SHALL clear whenever the synchronized level equals the debounced output.
REQ-013 Per input, the counter SHALL increment each cycle the synchronized level differs from the debounced output.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced output SHALL take the new level on that edge and the counter SHALL clear.
REQ-015 Raw-edge-to-debounced-output latency SHALL be exactly 2+DEBOUNCE_CYCLES cycles for a clean edge.
REQ-016 A pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on sw_db, key_db or key_press.
REQ-017 key_press[i] SHALL be high for exactly one cycle, coincident with the first cycle key_db[i] reads 0.
REQ-018 No pulse SHALL be generated on key release (key_db 0->1).
REQ-019 Auto-repeat FSM per key with states IDLE, DELAY, REPEAT; IDLE->DELAY on press pulse.
REQ-020 In DELAY, after REPEAT_DELAY cycles with key_db still 0: one key_press pulse, move to REPEAT.
REQ-021 In REPEAT, every REPEAT_PERIOD cycles with key_db still 0: one key_press pulse.
REQ-022 In DELAY or REPEAT, key_db returning to 1 SHALL force IDLE on the same edge with no further pulses.
REQ-023 Auto-repeat SHALL apply to key2 and key3 (bits 1,2) only; key0 (alarm reset, bit 0) SHALL never repeat.
REQ-024 Channels SHALL be fully independent; simultaneous presses SHALL each produce their own pulses in the same cycle.
REQ-025 Counter widths SHALL be $clog2 of the relevant parameter; no counter SHALL wrap while active.

Reset
REQ-026 reset SHALL asynchronously clear all synchronizer flops, counters and FSMs to the inactive level (switches 0, keys 1, FSM IDLE).
REQ-027 During and after reset: sw_db=4'b0000, key_db=3'b111, key_press=3'b000.
REQ-028 Reset mid-debounce or mid-repeat SHALL discard progress; a key still held after reset SHALL be re-debounced and yield one fresh press pulse.

Configuration
REQ-029 With macro INPUT_AUTO_REPEAT_EN defined, REQ-019..REQ-023 SHALL be implemented.
REQ-030 Without INPUT_AUTO_REPEAT_EN, key_press SHALL carry only the single press pulse of REQ-017 and no repeat counters SHALL be synthesized.

Structure
REQ-031 Shared package clock_input_pkg SHALL hold the default parameter constants, the repeat FSM state typedef, and the key bit-index constants (KEY0=0, KEY2=1, KEY3=2).
REQ-032 A sub-module debounce_cell (synchronizer + counter + level output, one bit) SHALL be instantiated 7 times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-033 sw_raw[0] 0->1 clean -> sw_db[0]=1 exactly 6 cycles later; no other output changes.
REQ-034 key_raw[1] low for 3 cycles then high -> key_db and key_press unchanged.
REQ-035 key_raw[1] held low 30 cycles -> pulse at cycle 6, 16, 19, 22, 25, 28; release -> no further pulse, key_db[1]=1 after 6 cycles.
REQ-036 key_raw[0] held low 30 cycles -> exactly one key_press[0] pulse.
REQ-037 key_raw[1] and key_raw[2] pressed same cycle -> key_press=3'b110 in one cycle.
REQ-038 reset asserted at cycle 12 of a held key3, released at 14 -> outputs at reset values during reset; fresh pulse 6 cycles after release.

Source files
------------

// File: rtl/clock_input_pkg.sv
// -----------------------------------------------------------------------------
// clock_input_pkg
//   Shared definitions for the clock front-panel input conditioner.
//   Contents:
//     - default timing constants for debounce and key auto-repeat
//     - channel counts and key bit indices (KEY0 = alarm reset, no repeat)
//     - auto-repeat FSM state type
//     - cnt_width(): width of a counter that must hold values 0..n-1
// -----------------------------------------------------------------------------
package clock_input_pkg;

  // Default timing for a 50 MHz clock: 5 ms debounce, 0.5 s repeat delay,
  // 0.1 s repeat period.
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  localparam int NUM_SW  = 4;
  localparam int NUM_KEY = 3;

  // Bit positions inside key_raw / key_db / key_press.
  localparam int KEY0 = 0;
  localparam int KEY2 = 1;
  localparam int KEY3 = 2;

  // Keys that auto-repeat while held. KEY0 clears the alarm and must fire once.
  localparam logic [NUM_KEY-1:0] KEY_REPEAT_MASK =
    (NUM_KEY'(1) << KEY2) | (NUM_KEY'(1) << KEY3);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
//   One-bit input conditioner: 2-flop synchronizer followed by a stability
//   counter. The debounced level follows the synchronized input only after the
//   input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//
//   Parameters:
//     DEBOUNCE_CYCLES  stable cycles needed to accept a new level (>= 2)
//     IDLE_LEVEL       inactive level, used as the reset value everywhere
//   Ports:
//     clk      in   clock
//     reset    in   asynchronous active-high reset
//     raw      in   asynchronous input
//     level    out  debounced level
//     flip     out  high in the cycle whose closing edge updates level
//     changed  out  high for the first cycle level shows a new value
// -----------------------------------------------------------------------------
module debounce_cell
  import clock_input_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic flip,
  output logic changed
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ;

  // NOTE: synchronizer flops reset to the idle level, so leaving reset with the
  // input already idle never looks like an edge to the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= IDLE_LEVEL;
      sync_q    <= IDLE_LEVEL;
    end else begin
      // NOTE: non-blocking assignments keep these two real pipeline stages;
      // blocking ones would let sync_q see this cycle's sync_meta and collapse
      // the synchronizer to a single flop.
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  assign differ = sync_q ^ level;

  // The counter has already seen DEBOUNCE_CYCLES-1 differing cycles; this is
  // the last one, so the level is accepted on the closing edge.
  assign flip = differ && (cnt_q == CNT_LAST);

  // The counter only runs while differing and is cleared when it reaches
  // CNT_LAST, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level   <= IDLE_LEVEL;
      changed <= 1'b0;
    end else begin
      changed <= flip;
      if (!differ || flip) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flip) begin
        level <= sync_q;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Debounces the four slide switches and three pushbuttons of the clock front
//   panel and turns key presses into single-cycle pulses. With
//   INPUT_AUTO_REPEAT_EN defined, KEY2 and KEY3 also auto-repeat while held;
//   KEY0 (alarm reset) never repeats. Without the macro no repeat logic exists.
//
//   Configuration macro: INPUT_AUTO_REPEAT_EN
//
//   Parameters:
//     DEBOUNCE_CYCLES  stable cycles to accept a new level (>= 2)
//     REPEAT_DELAY     cycles from press pulse to first repeat pulse
//     REPEAT_PERIOD    cycles between later repeat pulses
//   Ports:
//     clk        in   [1]  clock
//     reset      in   [1]  asynchronous active-high reset
//     sw_raw     in   [4]  {sw4,sw3,sw2,sw1}, active-high, asynchronous
//     key_raw    in   [3]  {key3,key2,key0}, active-low, asynchronous
//     sw_db      out  [4]  debounced switches, active-high
//     key_db     out  [3]  debounced keys, active-low
//     key_press  out  [3]  single-cycle press / repeat pulses, active-high
// -----------------------------------------------------------------------------
module input_conditioner
  import clock_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [NUM_KEY-1:0] key_raw,
  output logic [NUM_SW-1:0]  sw_db,
  output logic [NUM_KEY-1:0] key_db,
  output logic [NUM_KEY-1:0] key_press
);

  // Switch cells only supply their level; the event outputs have no consumer.
  logic [NUM_SW-1:0]  sw_flip_unused;
  logic [NUM_SW-1:0]  sw_changed_unused;

  logic [NUM_KEY-1:0] key_flip;
  logic [NUM_KEY-1:0] key_changed;
  logic [NUM_KEY-1:0] press;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (1'b0)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .raw     (sw_raw[i]),
      .level   (sw_db[i]),
      .flip    (sw_flip_unused[i]),
      .changed (sw_changed_unused[i])
    );
  end

  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (1'b1)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .raw     (key_raw[i]),
      .level   (key_db[i]),
      .flip    (key_flip[i]),
      .changed (key_changed[i])
    );
  end

  // A key change that leaves the key at 0 is a press; a change back to 1 is a
  // release and produces nothing. The pulse lines up with the first cycle
  // key_db reads 0.
  assign press = key_changed & ~key_db;

`ifdef INPUT_AUTO_REPEAT_EN

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                          : REPEAT_PERIOD;
  localparam int               RPT_W       = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [NUM_KEY-1:0] rpt_pulse;

  for (genvar i = 0; i < NUM_KEY; i++) begin : g_rpt
    if (KEY_REPEAT_MASK[i]) begin : g_on
      rpt_state_e       state_q;
      rpt_state_e       state_d;
      logic [RPT_W-1:0] cnt_q;
      logic [RPT_W-1:0] cnt_d;
      logic             pulse;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= RPT_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // cnt_q reads j-1 in the j-th cycle after entering DELAY or REPEAT, so
      // a pulse at cnt_q == LAST lands exactly REPEAT_DELAY / REPEAT_PERIOD
      // cycles after the previous pulse. key_flip in DELAY/REPEAT means the
      // key is released on the closing edge: the FSM drops to IDLE on that
      // same edge. key_db is still 0 in that cycle, so a pulse due then fires.
      always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse   = 1'b0;
        unique case (state_q)
          RPT_IDLE: begin
            if (press[i]) begin
              state_d = RPT_DELAY;
              cnt_d   = '0;
            end
          end
          RPT_DELAY: begin
            if (cnt_q == DELAY_LAST) begin
              pulse   = 1'b1;
              state_d = RPT_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + RPT_W'(1);
            end
            if (key_flip[i]) begin
              state_d = RPT_IDLE;
              cnt_d   = '0;
            end
          end
          RPT_REPEAT: begin
            if (cnt_q == PERIOD_LAST) begin
              pulse = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + RPT_W'(1);
            end
            if (key_flip[i]) begin
              state_d = RPT_IDLE;
              cnt_d   = '0;
            end
          end
          default: begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      assign rpt_pulse[i] = pulse;
    end else begin : g_off
      logic unused_flip;
      assign unused_flip  = key_flip[i];
      assign rpt_pulse[i] = 1'b0;
    end
  end

  assign key_press = press | rpt_pulse;

`else

  // Repeat timing and release events have no consumer in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{key_flip, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};

  assign key_press = press;

`endif

endmodule
